// File: rtl/s4ga_cfg_seq.sv
// Configuration sequencer for the s4ga LUT fabric: stores one bitstream loaded over a
// valid/ready segment port and replays it pass after pass into the fabric's serial input.
module s4ga_cfg_seq #(
    parameter int N       = 71,
    parameter int K       = 5,
    parameter int SI_W    = 4,
    parameter int RST_CYC = N + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [SI_W-1:0] wr_data,
    input  logic            run_en,
    output logic            fab_rst,
    output logic [SI_W-1:0] fab_si,
    output logic            cfg_valid,
    output logic            busy,
    output logic            pass_done,
    output logic [15:0]     pass_cnt
);

    // A LUT frame carries K input selectors of clog2(N) bits each plus a 2**K-bit truth table.
    localparam int SEL_SEGS = ($clog2(N) + SI_W - 1) / SI_W;
    localparam int TT_SEGS  = ((2 ** K) + SI_W - 1) / SI_W;
    localparam int LL       = K * SEL_SEGS + TT_SEGS;
    localparam int TOTAL    = N * LL;
    localparam int PTR_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TOTAL - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [RC_W-1:0]  RC_ZERO  = {RC_W{1'b0}};
    localparam logic [SI_W-1:0]  SEG_ZERO = {SI_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RSTH = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = PTR_ZERO;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    state_t          state_r, state_nx;
    logic [PTR_W-1:0] wp_r, wp_nx;
    logic [PTR_W-1:0] rp_r, rp_nx;
    logic [RC_W-1:0]  rc_r, rc_nx;
    logic            cfg_valid_r, cfg_valid_nx;
    logic [15:0]     pass_cnt_r, pass_cnt_nx;
    logic            pass_done_r, pass_done_nx;
    logic            fab_rst_r, fab_rst_nx;
    logic [SI_W-1:0] fab_si_r, fab_si_nx;
    logic            wr_ready_r, wr_ready_nx;
    logic            busy_r, busy_nx;
    logic            mem_we_s;
    logic [SI_W-1:0] mem_r [TOTAL];

    // Next-state and bookkeeping for the load / reset-hold / replay sequence.
    always_comb begin
        state_nx     = state_r;
        wp_nx        = wp_r;
        rp_nx        = rp_r;
        rc_nx        = rc_r;
        cfg_valid_nx = cfg_valid_r;
        pass_cnt_nx  = pass_cnt_r;
        pass_done_nx = 1'b0;
        mem_we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    wp_nx        = PTR_ZERO;
                    cfg_valid_nx = 1'b0;
                    state_nx     = ST_LOAD;
                end else if (run_en && cfg_valid_r) begin
                    rc_nx    = RC_ZERO;
                    state_nx = ST_RSTH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (wr_valid) begin
                    mem_we_s = 1'b1;
                    wp_nx    = ptr_inc(wp_r);
                    if (wp_r == LAST_PTR) begin
                        cfg_valid_nx = 1'b1;
                        state_nx     = ST_IDLE;
                    end else begin
                        state_nx = ST_LOAD;
                    end
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            ST_RSTH: begin
                if (rc_r == RC_LAST) begin
                    rp_nx       = PTR_ZERO;
                    pass_cnt_nx = 16'd0;
                    state_nx    = ST_RUN;
                end else begin
                    rc_nx = rc_r + RC_W'(1);
                end
            end
            ST_RUN: begin
                rp_nx = ptr_inc(rp_r);
                // Stopping is only decided on the last segment, so a pass is never cut short.
                if (rp_r == LAST_PTR) begin
                    pass_done_nx = 1'b1;
                    pass_cnt_nx  = pass_cnt_r + 16'd1;
                    if (run_en) begin
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered.
    always_comb begin
        fab_rst_nx  = (state_nx != ST_RUN);
        wr_ready_nx = (state_nx == ST_LOAD);
        busy_nx     = (state_nx != ST_IDLE);
        if (state_nx == ST_RUN) begin
            fab_si_nx = mem_r[rp_nx];
        end else begin
            fab_si_nx = SEG_ZERO;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wp_r        <= PTR_ZERO;
            rp_r        <= PTR_ZERO;
            rc_r        <= RC_ZERO;
            cfg_valid_r <= 1'b0;
            pass_cnt_r  <= 16'd0;
            pass_done_r <= 1'b0;
            fab_rst_r   <= 1'b1;
            fab_si_r    <= SEG_ZERO;
            wr_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            wp_r        <= wp_nx;
            rp_r        <= rp_nx;
            rc_r        <= rc_nx;
            cfg_valid_r <= cfg_valid_nx;
            pass_cnt_r  <= pass_cnt_nx;
            pass_done_r <= pass_done_nx;
            fab_rst_r   <= fab_rst_nx;
            fab_si_r    <= fab_si_nx;
            wr_ready_r  <= wr_ready_nx;
            busy_r      <= busy_nx;
        end
    end

    // Bitstream storage; contents survive reset and are simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wp_r] <= wr_data;
        end
    end

    assign wr_ready  = wr_ready_r;
    assign fab_rst   = fab_rst_r;
    assign fab_si    = fab_si_r;
    assign cfg_valid = cfg_valid_r;
    assign busy      = busy_r;
    assign pass_done = pass_done_r;
    assign pass_cnt  = pass_cnt_r;

endmodule

// File: doc/s4ga_cfg_seq.md
Name: s4ga_cfg_seq

Overview:
Configuration sequencer for the s4ga LUT fabric. It holds one complete bitstream, meaning N LUT frames of LL SI_W-bit segments each. It drives the fabric's serial config input and reset, and replays the bitstream continuously so the fabric evaluates pass after pass. A host loads the bitstream through a valid/ready segment interface, then starts and stops evaluation with a level enable.

Parameters:
N, 71, number of LUTs in the driven fabric
K, 5, LUT inputs
SI_W, 4, segment width in bits
RST_CYC, N+1, fabric reset hold in cycles; must be >N
LL (derived), K*ceil(clog2(N)/SI_W) + ceil(2**K/SI_W), segments per LUT frame
TOTAL (derived), N*LL, segments per pass

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse; in IDLE, clears the write pointer and enters LOAD
wr_valid  in  1  host segment valid
wr_ready  out  1  high only in LOAD
wr_data  in  SI_W  host segment
run_en  in  1  level; request continuous evaluation
fab_rst  out  1  registered; drives fabric rst
fab_si  out  SI_W  registered; drives fabric si
cfg_valid  out  1  a complete bitstream is loaded
busy  out  1  state != IDLE
pass_done  out  1  one-cycle pulse at the end of each pass
pass_cnt  out  16  completed passes since entering RUN; wraps

Behaviour:
- Storage: TOTAL x SI_W register file. Write pointer wp and read pointer rp, each clog2(TOTAL) bits.
- Reset (rst_n=0, async): state=IDLE, fab_rst=1, fab_si=0, cfg_valid=0, wr_ready=0, pass_done=0, pass_cnt=0, wp=rp=0. Memory contents are not reset.
- IDLE: fab_rst=1, fab_si=0.
  - load_start has priority over run_en: wp<=0, cfg_valid<=0, go LOAD.
  - Else if run_en && cfg_valid: rc<=0, go RSTH.
  - Else run_en is ignored.
- LOAD: wr_ready=1. On wr_valid && wr_ready, mem[wp]<=wr_data and wp++.
  - The accept at wp==TOTAL-1 sets cfg_valid<=1 and goes IDLE; wr_ready drops the next cycle.
  - load_start and run_en are ignored in LOAD.
- RSTH: fab_rst=1, fab_si=0 for exactly RST_CYC cycles, counted with rc. Then rp<=0, pass_cnt<=0, go RUN.
- RUN: fab_rst=0, fab_si<=mem[rp] (registered), rp wraps TOTAL-1 -> 0.
  - The first RUN cycle presents segment 0.
  - Segment j of pass p appears on fab_si exactly once, at cycle p*TOTAL + j after RUN entry.
  - When rp==TOTAL-1 is presented, pass_done pulses one cycle later and pass_cnt increments in the same cycle.
- Stop: run_en low in RUN is sampled each cycle. The current pass completes with its last segment presented. The next cycle is IDLE (fab_rst=1, fab_si=0). A pass is never truncated. run_en reasserting before the last segment cancels the stop.
- load_start outside IDLE is ignored; busy=1 in LOAD, RSTH and RUN.
- Partial loads: cfg_valid stays 0 until all TOTAL segments are accepted. A fresh load_start after an aborting reset restarts at wp=0.
- Reset mid-operation: immediate return to the reset values above. The bitstream must be reloaded (cfg_valid=0).
- Width rules: pointers compare against TOTAL-1 with no overflow past it. pass_cnt wraps 0xFFFF -> 0.

Test Plan:
- Use N=5, K=2, SI_W=4 (LL=3, TOTAL=15, RST_CYC=6) unless stated.
- Reset, then run_en=1 with no load -> stays IDLE; fab_rst=1, fab_si=0, busy=0, cfg_valid=0.
- load_start, then 15 segments 0x0..0xE with wr_valid gaps every 3rd cycle -> exactly 15 accepts; cfg_valid=1 after the 15th accept; wr_ready=0 afterwards.
- run_en=1 -> fab_rst=1 for exactly 6 cycles, then fab_si = 0,1,...,14,0,1,...; pass_done pulses every 15 cycles; pass_cnt = 1, 2, 3.
- Drop run_en while segment 0x4 is presented -> segments 0x5..0xE still emitted, pass_done pulses, then IDLE with fab_rst=1; a load_start during RUN had no effect.
- Assert rst_n low mid-LOAD after 7 segments -> all outputs at reset values immediately; cfg_valid=0; a later run_en is ignored until a full reload.
- Assert load_start and run_en in the same IDLE cycle with cfg_valid=1 -> enters LOAD (wr_ready=1) and cfg_valid clears.
